// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: owns the fetch PC, issues single-outstanding imem requests and buffers (inst, pc) pairs for decode.
// Optional feature macro IFU_MISALIGN_TRAP_EN: misaligned redirects set a sticky misalign_err and halt fetch.
module ifu_fetch_queue #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WAIT_DROP} fetchStateT;

  fetchStateT       state, stateNext;
  logic [XLEN-1:0]  fetchPc, fetchPcNext, addrReg;
  logic             pending, dropPending, dropNext;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rdPtr, wrPtr;
  logic [ILEN-1:0]  instMem [DEPTH];
  logic [XLEN-1:0]  pcMem [DEPTH];
  logic             reqValid, handshake, respPush, pop;
  logic             misalignErr, redirBad;
  logic [XLEN-1:0]  redirTarget;

`ifdef IFU_MISALIGN_TRAP_EN
  assign redirTarget = redirect_pc;
  assign redirBad    = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)
      misalignErr <= 1'b0;
    else if (redirect_valid)
      misalignErr <= redirBad;
  end
`else
  assign redirTarget = redirect_pc & ~XLEN'(3);
  assign redirBad    = 1'b0;
  assign misalignErr = 1'b0;
`endif

  // A raised request stays up (with its address frozen) until accepted, even across a redirect or error.
  assign reqValid  = !rst && (state == IDLE || state == REQ) &&
                     (pending || (count < CNT_W'(DEPTH) && !misalignErr));
  assign handshake = reqValid && imem_req_ready;
  assign respPush  = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop       = inst_valid && inst_ready;

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    dropNext    = dropPending;
    case (state)
      IDLE, REQ: begin
        if (handshake) begin
          stateNext = (dropPending || redirect_valid) ? WAIT_DROP : WAIT;
          if (!dropPending && !redirect_valid)
            fetchPcNext = fetchPc + XLEN'(4);
          dropNext = 1'b0;
        end else begin
          stateNext = REQ;
          if (redirect_valid && reqValid)
            dropNext = 1'b1;
        end
      end
      // A response arriving with a redirect is consumed (and dropped), so no wait for another one.
      WAIT: begin
        if (imem_resp_valid)
          stateNext = REQ;
        else if (redirect_valid)
          stateNext = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (imem_resp_valid)
          stateNext = REQ;
      end
      default: stateNext = IDLE;
    endcase
    if (redirect_valid && !redirBad)
      fetchPcNext = redirTarget;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetchPc     <= RESET_PC;
      addrReg     <= RESET_PC;
      pending     <= 1'b0;
      dropPending <= 1'b0;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else begin
      state       <= stateNext;
      fetchPc     <= fetchPcNext;
      dropPending <= dropNext;
      pending     <= reqValid && !imem_req_ready;
      if (reqValid)
        addrReg <= imem_req_addr;
      if (redirect_valid) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (respPush)
          wrPtr <= wrPtr + PTR_W'(1);
        if (pop)
          rdPtr <= rdPtr + PTR_W'(1);
        count <= count + CNT_W'(respPush) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instMem[i] <= '0;
        pcMem[i]   <= '0;
      end
    end else if (respPush) begin
      instMem[wrPtr] <= imem_resp_inst;
      pcMem[wrPtr]   <= addrReg;
    end
  end

  assign imem_req_valid = reqValid;
  assign imem_req_addr  = pending ? addrReg : fetchPc;
  assign inst_valid     = (count != '0);
  assign inst           = instMem[rdPtr];
  assign inst_pc        = pcMem[rdPtr];
  assign misalign_err   = misalignErr;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed scenarios plus random traffic against a queue-based fetch-stream model.
// Honours IFU_MISALIGN_TRAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_ifu_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign_err;

  ifu_fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int passCnt = 0, checkCnt = 0;
  int readyPct = 100, memLatMin = 1, memLatMax = 1;
  bit constInst = 1'b1;

  function automatic logic [31:0] memInst(input logic [63:0] a);
    return constInst ? 32'h0000_0013 : (a[31:0] ^ a[63:32] ^ 32'h1357_9BDF);
  endfunction

  // Memory agent: one outstanding request, response after a random latency, forgets everything on rst.
  bit          memBusy = 1'b0;
  int          memCnt;
  logic [63:0] memAddr;
  initial begin
    bit          hs, rs, rv;
    logic [63:0] hsAddr;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_inst  = '0;
    forever begin
      @(negedge clk);
      imem_req_ready  = ($urandom_range(99) < readyPct);
      imem_resp_valid = 1'b0;
      if (memBusy) begin
        if (memCnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_inst  = memInst(memAddr);
        end else begin
          memCnt--;
        end
      end
      #4;
      hs = imem_req_valid && imem_req_ready && !rst;
      hsAddr = imem_req_addr;
      rs = rst;
      rv = imem_resp_valid;
      @(posedge clk);
      if (rs) begin
        memBusy = 1'b0;
      end else begin
        if (rv) memBusy = 1'b0;
        if (hs) begin
          memBusy = 1'b1;
          memAddr = hsAddr;
          memCnt  = int'($urandom_range(memLatMax, memLatMin)) - 1;
        end
      end
    end
  end

  // Reference: expected fetch stream PC, queue contents, and the fate of in-flight requests.
  logic [63:0] mQ[$];
  logic [63:0] keptLog[$];
  logic [63:0] mPc, mOutAddr, mHeldAddr;
  bit mOut, mOutKept, mHeld, mHeldDoomed, mErr, lastResp;
  int cyc = 0, accCnt, relCyc, firstAcc, firstVld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    assert (got === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic modelReset();
    mQ.delete();
    mOut = 0; mOutKept = 0; mHeld = 0; mHeldDoomed = 0; mErr = 0;
    mPc = RESET_PC;
    accCnt = 0; relCyc = -1; firstAcc = -1; firstVld = -1;
  endtask

  // One clock: called at a negedge after inputs are set; returns at the next negedge.
  task automatic tick();
    logic expValid;
    #3;
    cyc++;
    expValid = !rst && !mOut && (mHeld || (mQ.size() < DEPTH && !mErr));
    check("req_valid", imem_req_valid, expValid);
    if (imem_req_valid && expValid)
      check("req_addr", imem_req_addr, mHeld ? mHeldAddr : mPc);
    check("inst_valid", inst_valid, mQ.size() != 0);
    if (mQ.size() != 0) begin
      check("inst_pc", inst_pc, mQ[0]);
      check("inst", inst, memInst(mQ[0]));
    end
    check("misalign_err", misalign_err, mErr);
    lastResp = imem_resp_valid;
    if (rst) begin
      modelReset();
    end else begin
      if (relCyc < 0) relCyc = cyc;
      if (inst_valid && firstVld < 0) firstVld = cyc;
      if (inst_valid && inst_ready && mQ.size() != 0) void'(mQ.pop_front());
      if (imem_resp_valid && mOut) begin
        mOut = 0;
        if (mOutKept && !redirect_valid) mQ.push_back(mOutAddr);
      end
      if (imem_req_valid && imem_req_ready) begin
        accCnt++;
        if (firstAcc < 0) firstAcc = cyc;
        mOut = 1;
        mOutAddr = imem_req_addr;
        mOutKept = !mHeldDoomed && !redirect_valid;
        if (mOutKept) begin
          mPc = mPc + 64'd4;
          keptLog.push_back(imem_req_addr);
        end
        mHeld = 0; mHeldDoomed = 0;
      end else if (imem_req_valid) begin
        mHeld = 1;
        mHeldAddr = imem_req_addr;
        if (redirect_valid) mHeldDoomed = 1;
      end
      if (redirect_valid) begin
        mQ.delete();
        mOutKept = 0;
`ifdef IFU_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) mErr = 1;
        else begin mErr = 0; mPc = redirect_pc; end
`else
        mPc = {redirect_pc[63:2], 2'b00};
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic waitKept(input int n, input int budget);
    for (int i = 0; i < budget && keptLog.size() < n; i++) tick();
    check("kept_timeout", keptLog.size() >= n, 1'b1);
  endtask

  task automatic redirectTo(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rp;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    modelReset();
    @(negedge clk);
    tick(); tick();
    check("rst_addr", imem_req_addr, RESET_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 64'h0);

    // Reset release, 1-cycle memory returning nops
    keptLog.delete();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("first_req_cycle", firstAcc, relCyc);
    check("first_valid_lat", firstVld - firstAcc, 2);
    check("seq0", keptLog[0], 64'h8000_0000);
    check("seq1", keptLog[1], 64'h8000_0004);
    check("seq2", keptLog[2], 64'h8000_0008);

    // Decode stalled: exactly DEPTH requests, then drain in order
    rst = 1'b1; inst_ready = 1'b0; tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("full_accepts", accCnt, DEPTH);
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("resume_accepts", accCnt > DEPTH, 1'b1);

    // Redirect while a slow response is outstanding
    rst = 1'b1; memLatMin = 4; memLatMax = 4; tick();
    rst = 1'b0;
    for (int i = 0; i < 10 && accCnt < 1; i++) tick();
    check("slow_accept", accCnt, 1);
    keptLog.delete();
    redirectTo(64'h8000_0100);
    waitKept(1, 20);
    if (keptLog.size() >= 1) check("redir_addr", keptLog[0], 64'h8000_0100);

    // Redirect and response on the same edge with two queued entries
    rst = 1'b1; memLatMin = 1; memLatMax = 1; inst_ready = 1'b0; tick();
    rst = 1'b0;
    for (int i = 0; i < 40 && !(mQ.size() == 2 && mOut); i++) tick();
    check("two_queued", mQ.size(), 2);
    keptLog.delete();
    redirectTo(64'h8000_0200);
    check("same_edge_resp", lastResp, 1'b1);
    check("flush_valid", inst_valid, 1'b0);
    inst_ready = 1'b1;
    waitKept(1, 20);
    if (keptLog.size() >= 1) check("flush_addr", keptLog[0], 64'h8000_0200);

    // PC wrap
    keptLog.delete();
    redirectTo(64'hFFFF_FFFF_FFFF_FFFC);
    waitKept(2, 40);
    if (keptLog.size() >= 2) begin
      check("wrap0", keptLog[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap1", keptLog[1], 64'h0);
    end

    // Misaligned redirect
    keptLog.delete();
    redirectTo(64'h8000_0002);
`ifdef IFU_MISALIGN_TRAP_EN
    check("misalign_set", misalign_err, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("misalign_stop", keptLog.size(), 0);
    check("misalign_idle", imem_req_valid, 1'b0);
    redirectTo(64'h8000_0008);
    check("misalign_clr", misalign_err, 1'b0);
    waitKept(1, 20);
    if (keptLog.size() >= 1) check("misalign_resume", keptLog[0], 64'h8000_0008);
`else
    check("misalign_tied", misalign_err, 1'b0);
    waitKept(1, 20);
    if (keptLog.size() >= 1) check("misalign_forced", keptLog[0], 64'h8000_0000);
`endif

    // Random traffic
    rst = 1'b1; tick();
    constInst = 1'b0; readyPct = 60; memLatMin = 1; memLatMax = 3;
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom_range(99) < 70);
      redirect_valid = ($urandom_range(99) < 6);
      case ($urandom_range(2))
        0: rp = 64'h8000_0000 + 64'($urandom_range(1023));
        1: rp = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom_range(255))};
        default: rp = {$urandom, $urandom};
      endcase
      if ($urandom_range(9) != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
